// File: rtl/ctrl_cmd_frontend.sv
// Purpose: buffers host cache requests and issues them one at a time to the controller FSM, then returns one response for each.
// Latency: a push into an idle, empty block gives cmd_valid_o 2 cycles later, and an illegal op gives rsp_valid_o 2 cycles later.
// Backpressure: req_ready_o drops while the FIFO is full; cmd and rsp stay valid and stable until their handshakes complete.
module ctrl_cmd_frontend #(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [2:0]             req_op_i,
    input  logic [KEY_WIDTH-1:0]   req_key_i,
    input  logic [VALUE_WIDTH-1:0] req_value_i,
    output logic                   cmd_valid_o,
    output logic [2:0]             cmd_op_o,
    output logic [KEY_WIDTH-1:0]   cmd_key_o,
    output logic [VALUE_WIDTH-1:0] cmd_value_o,
    input  logic                   cmd_ack_i,
    input  logic                   ctrl_done_i,
    input  logic                   ctrl_error_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [2:0]             rsp_op_o,
    output logic                   rsp_error_o,
    output logic                   rsp_timeout_o,
    output logic                   busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]       OP_NOOP   = 3'd0;
    localparam logic [2:0]       OP_DELETE = 3'd4;

    typedef struct packed {
        logic [2:0]             op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    req_t             mem [DEPTH];
    req_t             push_dat;
    req_t             head_dat;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    state_t           state_q, state_d;
    req_t             iss_q, iss_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    assign req_ready_o = (count_q != FULL_CNT);
    // NOOPs complete the handshake but never occupy a slot.
    assign push        = req_valid_i && req_ready_o && (req_op_i != OP_NOOP);
    assign push_dat    = '{op: req_op_i, key: req_key_i, value: req_value_i};
    assign head_dat    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iss_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        wdog_d  = wdog_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    iss_d = head_dat;
                    tmo_d = 1'b0;
                    // Illegal opcodes never reach the controller.
                    if (head_dat.op > OP_DELETE) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ack_i) begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Status takes priority over the watchdog expiring in the same cycle.
                if (ctrl_done_i || ctrl_error_i) begin
                    err_d   = ctrl_error_i;
                    state_d = S_RESP;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_valid_o   = (state_q == S_ISSUE);
    assign cmd_op_o      = iss_q.op;
    assign cmd_key_o     = iss_q.key;
    assign cmd_value_o   = iss_q.value;
    assign rsp_valid_o   = (state_q == S_RESP);
    assign rsp_op_o      = iss_q.op;
    assign rsp_error_o   = rsp_valid_o && err_q;
    assign rsp_timeout_o = rsp_valid_o && tmo_q;
    assign busy_o        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ctrl_cmd_frontend.sv
// Directed bench for ctrl_cmd_frontend: exact-cycle checks of issue, response, FIFO, watchdog and reset behaviour.
module tb_ctrl_cmd_frontend;

    localparam int KW = 16;
    localparam int VW = 64;
    localparam int DP = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [KW-1:0] req_key;
    logic [VW-1:0] req_value;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [KW-1:0] cmd_key;
    logic [VW-1:0] cmd_value;
    logic          cmd_ack;
    logic          ctrl_done;
    logic          ctrl_error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_op;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          busy;

    int checks = 0;
    int passed = 0;

    logic [2:0] fo_ops [5];

    ctrl_cmd_frontend #(
        .KEY_WIDTH  (KW),
        .VALUE_WIDTH(VW),
        .DEPTH      (DP),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_key_i    (req_key),
        .req_value_i  (req_value),
        .cmd_valid_o  (cmd_valid),
        .cmd_op_o     (cmd_op),
        .cmd_key_o    (cmd_key),
        .cmd_value_o  (cmd_value),
        .cmd_ack_i    (cmd_ack),
        .ctrl_done_i  (ctrl_done),
        .ctrl_error_i (ctrl_error),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_op_o     (rsp_op),
        .rsp_error_o  (rsp_error),
        .rsp_timeout_o(rsp_timeout),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 3'd0; req_key = '0; req_value = '0;
        cmd_ack = 1'b0; ctrl_done = 1'b0; ctrl_error = 1'b0; rsp_ready = 1'b0;
        step();
        step();
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else passed++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if ({rsp_error, rsp_timeout} !== 2'b00) $display("FAIL rst_rsp_flags: got %b want 00", {rsp_error, rsp_timeout}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if ({cmd_op, cmd_key, cmd_value, rsp_op} !== '0) $display("FAIL rst_payload: op %h key %h val %h rsp_op %h want all 0", cmd_op, cmd_key, cmd_value, rsp_op); else passed++;
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_single_read();
        drive_req(3'd1, 16'h0012, 64'h0123_4567_89AB_CDEF);
        step();
        req_valid = 1'b0;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL read_t1_cmd_valid: got %b want 0", cmd_valid); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL read_t1_busy: got %b want 1", busy); else passed++;
        step();
        checks++; if (cmd_valid !== 1'b1) $display("FAIL read_t2_cmd_valid: got %b want 1", cmd_valid); else passed++;
        checks++; if (cmd_op !== 3'd1) $display("FAIL read_t2_cmd_op: got %0d want 1", cmd_op); else passed++;
        checks++; if (cmd_key !== 16'h0012) $display("FAIL read_t2_cmd_key: got %h want 0012", cmd_key); else passed++;
        checks++; if (cmd_value !== 64'h0123_4567_89AB_CDEF) $display("FAIL read_t2_cmd_value: got %h want 0123456789abcdef", cmd_value); else passed++;
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        checks++; if ({cmd_valid, rsp_valid} !== 2'b00) $display("FAIL read_t3_valids: got %b want 00", {cmd_valid, rsp_valid}); else passed++;
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL read_t4_rsp_valid: got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_op !== 3'd1) $display("FAIL read_t4_rsp_op: got %0d want 1", rsp_op); else passed++;
        checks++; if ({rsp_error, rsp_timeout} !== 2'b00) $display("FAIL read_t4_rsp_flags: got %b want 00", {rsp_error, rsp_timeout}); else passed++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL read_t5_done: rsp_valid/busy got %b want 00", {rsp_valid, busy}); else passed++;
    endtask

    task automatic test_full_order();
        logic [KW-1:0] k;
        fo_ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        for (int i = 0; i < 5; i++) begin
            checks++; if (req_ready !== 1'b1) $display("FAIL full_push%0d_ready: got %b want 1", i, req_ready); else passed++;
            k = 16'h0100 + 16'(i);
            drive_req(fo_ops[i], k, 64'(i));
            step();
        end
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) $display("FAIL full_ready_low: got %b want 0", req_ready); else passed++;
        for (int i = 0; i < 5; i++) begin
            k = 16'h0100 + 16'(i);
            checks++; if (cmd_valid !== 1'b1) $display("FAIL order%0d_cmd_valid: got %b want 1", i, cmd_valid); else passed++;
            checks++; if ({cmd_op, cmd_key} !== {fo_ops[i], k}) $display("FAIL order%0d_cmd: got op %0d key %h want op %0d key %h", i, cmd_op, cmd_key, fo_ops[i], k); else passed++;
            cmd_ack = 1'b1;
            step();
            cmd_ack = 1'b0;
            ctrl_done = 1'b1;
            step();
            ctrl_done = 1'b0;
            checks++; if ({rsp_valid, rsp_op, rsp_error} !== {1'b1, fo_ops[i], 1'b0}) $display("FAIL order%0d_rsp: got valid %b op %0d err %b want 1 %0d 0", i, rsp_valid, rsp_op, rsp_error, fo_ops[i]); else passed++;
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            if (i == 0) begin
                checks++; if (req_ready !== 1'b0) $display("FAIL full_idle_ready: got %b want 0", req_ready); else passed++;
            end
            step();
            if (i == 0) begin
                checks++; if (req_ready !== 1'b1) $display("FAIL full_after_pop_ready: got %b want 1", req_ready); else passed++;
            end
        end
        checks++; if (busy !== 1'b0) $display("FAIL full_end_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_noop_illegal();
        drive_req(3'd0, 16'h0055, 64'h5);
        step();
        req_valid = 1'b0;
        checks++; if ({busy, req_ready} !== 2'b01) $display("FAIL noop_busy_ready: got %b want 01", {busy, req_ready}); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({cmd_valid, rsp_valid} !== 2'b00) $display("FAIL noop_no_activity%0d: got %b want 00", i, {cmd_valid, rsp_valid}); else passed++;
        end
        drive_req(3'd7, 16'h0077, 64'h7);
        step();
        req_valid = 1'b0;
        checks++; if ({cmd_valid, rsp_valid} !== 2'b00) $display("FAIL illegal_t1: cmd/rsp valid got %b want 00", {cmd_valid, rsp_valid}); else passed++;
        step();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL illegal_rsp_valid: got %b want 1", rsp_valid); else passed++;
        checks++; if ({rsp_op, rsp_error, rsp_timeout} !== {3'd7, 1'b1, 1'b0}) $display("FAIL illegal_rsp: got op %0d err %b tmo %b want 7 1 0", rsp_op, rsp_error, rsp_timeout); else passed++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL illegal_cmd_valid: got %b want 0", cmd_valid); else passed++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL illegal_done: got %b want 00", {rsp_valid, busy}); else passed++;
    endtask

    task automatic test_ctrl_error();
        drive_req(3'd4, 16'h0044, 64'h44);
        step();
        req_valid = 1'b0;
        step();
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        checks++; if ({cmd_valid, rsp_valid} !== 2'b10) $display("FAIL err_done_in_issue: cmd/rsp valid got %b want 10", {cmd_valid, rsp_valid}); else passed++;
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        ctrl_done = 1'b1;
        ctrl_error = 1'b1;
        step();
        ctrl_done = 1'b0;
        ctrl_error = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL err_rsp_valid: got %b want 1", rsp_valid); else passed++;
        checks++; if ({rsp_op, rsp_error, rsp_timeout} !== {3'd4, 1'b1, 1'b0}) $display("FAIL err_rsp: got op %0d err %b tmo %b want 4 1 0", rsp_op, rsp_error, rsp_timeout); else passed++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_watchdog(input logic done_last);
        drive_req(3'd3, 16'h0033, 64'h33);
        step();
        req_valid = 1'b0;
        step();
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
        end
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wdog%0d_early: rsp_valid got %b want 0", done_last, rsp_valid); else passed++;
        ctrl_done = done_last;
        step();
        ctrl_done = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL wdog%0d_rsp_valid: got %b want 1", done_last, rsp_valid); else passed++;
        checks++; if ({rsp_op, rsp_error, rsp_timeout} !== {3'd3, !done_last, !done_last}) $display("FAIL wdog%0d_rsp: got op %0d err %b tmo %b want 3 %b %b", done_last, rsp_op, rsp_error, rsp_timeout, !done_last, !done_last); else passed++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        drive_req(3'd1, 16'h0101, 64'h1);
        step();
        drive_req(3'd2, 16'h0202, 64'h2);
        step();
        req_valid = 1'b0;
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({cmd_valid, rsp_valid, rsp_error, rsp_timeout, busy, req_ready} !== 6'b000001) $display("FAIL midrst_ctrl: got %b want 000001", {cmd_valid, rsp_valid, rsp_error, rsp_timeout, busy, req_ready}); else passed++;
        checks++; if ({cmd_op, cmd_key, cmd_value, rsp_op} !== '0) $display("FAIL midrst_payload: op %h key %h val %h rsp_op %h want all 0", cmd_op, cmd_key, cmd_value, rsp_op); else passed++;
        step();
        rst_n = 1'b1;
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({cmd_valid, rsp_valid, busy} !== 3'b000) $display("FAIL midrst_quiet%0d: got %b want 000", i, {cmd_valid, rsp_valid, busy}); else passed++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        drive_req(3'd1, 16'h0AAA, 64'hA);
        step();
        drive_req(3'd2, 16'h0BBB, 64'hB);
        step();
        req_valid = 1'b0;
        checks++; if ({cmd_valid, cmd_op} !== {1'b1, 3'd1}) $display("FAIL bp_first_cmd: got %b/%0d want 1/1", cmd_valid, cmd_op); else passed++;
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if ({rsp_valid, rsp_op, rsp_error, cmd_valid} !== 6'b100100) $display("FAIL bp_hold%0d: valid/op/err/cmd got %b want 100100", i, {rsp_valid, rsp_op, rsp_error, cmd_valid}); else passed++;
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        checks++; if ({cmd_valid, cmd_op, cmd_key} !== {1'b1, 3'd2, 16'h0BBB}) $display("FAIL bp_second_cmd: got %b/%0d/%h want 1/2/0bbb", cmd_valid, cmd_op, cmd_key); else passed++;
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        checks++; if ({rsp_valid, rsp_op, rsp_error} !== {1'b1, 3'd2, 1'b0}) $display("FAIL bp_second_rsp: got %b/%0d/%b want 1/2/0", rsp_valid, rsp_op, rsp_error); else passed++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL bp_end_busy: got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_full_order();
        test_noop_illegal();
        test_ctrl_error();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/ctrl_cmd_frontend.md
# ctrl_cmd_frontend

Upstream command intake for the cache controller. Host requests (operation code, key, value) are accepted over a valid/ready handshake and buffered in a small FIFO. They are issued one at a time to the controller's top-level state machine. The block waits for the controller's done/error status and returns a single response per non-NOOP request, with a watchdog against a hung controller.

## Interface

Clock is `clk`; reset is `rst_n`, asynchronous and active-low.

Parameters:
- `KEY_WIDTH`, 16, key width in bits
- `VALUE_WIDTH`, 64, value width in bits
- `DEPTH`, 4, request FIFO entries; power of two, ≥2
- `TIMEOUT`, 255, maximum wait cycles for controller status; ≥2; counter width is clog2(TIMEOUT+1)

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid_i` in 1: host request valid
- `req_ready_o` out 1: FIFO can accept
- `req_op_i` in 3: operation code: NOOP=000, READ=001, CREATE=010, UPDATE=011, DELETE=100; 101–111 are illegal
- `req_key_i` in KEY_WIDTH: request key
- `req_value_i` in VALUE_WIDTH: request value
- `cmd_valid_o` out 1: command presented to controller
- `cmd_op_o` out 3: command operation code
- `cmd_key_o` out KEY_WIDTH: command key
- `cmd_value_o` out VALUE_WIDTH: command value
- `cmd_ack_i` in 1: controller accepted the command (leaving idle)
- `ctrl_done_i` in 1: sub-operation done (sub_cmd_t.done)
- `ctrl_error_i` in 1: sub-operation error (sub_cmd_t.error)
- `rsp_valid_o` out 1: response valid
- `rsp_ready_i` in 1: response consumer ready
- `rsp_op_o` out 3: operation code of the responded request
- `rsp_error_o` out 1: request failed (illegal op, controller error, or timeout)
- `rsp_timeout_o` out 1: failure was a watchdog timeout
- `busy_o` out 1: FSM not in S_IDLE, or FIFO non-empty

## Operation

- **Push:** on `req_valid_i && req_ready_o`, the request is written at the write pointer and count increments.
  - `req_ready_o` = (count != DEPTH). It is combinational from count only.
  - NOOP requests are accepted but not written; count is unchanged.
- **Pointers:** read and write pointers wrap modulo DEPTH. A push and a pop in the same cycle leave count unchanged.
- **FSM states:** S_IDLE, S_ISSUE, S_WAIT, S_RESP.
  - **S_IDLE:** if count > 0, load the head entry into the issue register and pop it.
    - Legal op: go to S_ISSUE.
    - Illegal op: go to S_RESP with error=1, timeout=0; no command is issued.
  - **S_ISSUE:** `cmd_valid_o`=1. Op, key and value are held stable from the issue register. On `cmd_ack_i`, clear the watchdog and go to S_WAIT.
  - **S_WAIT:** `ctrl_done_i` and `ctrl_error_i` are sampled only in this state.
    - If either is high: error = `ctrl_error_i` (done and error together gives error=1); go to S_RESP.
    - Otherwise the watchdog increments. When it reaches TIMEOUT-1 with no status: error=1, timeout=1; go to S_RESP.
  - **S_RESP:** `rsp_valid_o`=1 with `rsp_op_o`, `rsp_error_o` and `rsp_timeout_o` stable. On `rsp_ready_i`, go to S_IDLE.
- Status pulses arriving in S_IDLE, S_ISSUE or S_RESP are ignored.
- Strictly one command is outstanding. Responses are returned in request order.

## Timing

- **Reset values:**
  - `req_ready_o`=1 (FIFO empty).
  - `cmd_valid_o`, `rsp_valid_o`, `rsp_error_o`, `rsp_timeout_o` and `busy_o` are 0.
  - `cmd_*` payload and `rsp_op_o` are 0.
  - FSM is in S_IDLE; pointers, count and watchdog are 0.
- **Reset mid-operation:** FIFO contents and any in-flight command are discarded; no response is produced.
- **Minimum latency, push at cycle T into an empty FIFO with the FSM idle:**
  - T+1: S_IDLE pops.
  - T+2: `cmd_valid_o`=1.
  - With `cmd_ack_i` at T+2, the FSM is in S_WAIT at T+3.
  - With done at T+3, `rsp_valid_o`=1 at T+4.
- **Illegal op:** `rsp_valid_o`=1 two cycles after the push.
- **Back-pressure:** `cmd_valid_o` and `rsp_valid_o` stay high and payloads stay stable until their handshake completes.
- **Full FIFO:** `req_ready_o`=0. A pop in S_IDLE raises `req_ready_o` the next cycle.
- **Timeout:** the timeout response asserts TIMEOUT cycles after entry to S_WAIT. A status arriving on that same cycle wins: it is reported as a normal response, not a timeout.

## Test plan

- **Single READ:** READ key=0x0012 pushed; ack at the first `cmd_valid_o`; done one cycle later -> `cmd_op_o`=001 at T+2, `rsp_valid_o` at T+4, `rsp_op_o`=001, `rsp_error_o`=0.
- **Full FIFO and ordering:** push 5 requests back-to-back with the controller stalled (no ack) -> `req_ready_o`=0 after the 4th push into the FIFO (first entry already popped). Responses then return in push order with matching `rsp_op_o`.
- **NOOP and illegal ops:** NOOP push -> no response, count unchanged. Op 111 -> `rsp_error_o`=1, `rsp_timeout_o`=0, `cmd_valid_o` never asserted.
- **Controller error:** DELETE acked, then done=1 and error=1 together -> `rsp_error_o`=1, `rsp_timeout_o`=0. Done pulse during S_ISSUE -> ignored.
- **Watchdog:** TIMEOUT=8, UPDATE acked, no status -> `rsp_valid_o` with error=1, timeout=1 exactly 8 cycles after entering S_WAIT. Repeat with done on cycle 8 -> normal response.
- **Reset and back-pressure:** `rst_n` low during S_WAIT -> all outputs return to reset values and no stale response appears. `rsp_ready_i` held low for 10 cycles -> response held stable and the next command is not issued.
